// File: rtl/ex_stage_reg_if.sv
// rtl/ex_stage_reg_if.sv - ID/EX input and EX/MEM output bundle of the execute stage
// The ovf signal exists only when EX_OVF_TRAP_EN is defined.
interface ex_stage_reg_if;
  logic [2:0]  AluOP;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        RegDst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  dest_reg;
`ifdef EX_OVF_TRAP_EN
  logic        ovf;
`endif

  modport master (
`ifdef EX_OVF_TRAP_EN
    input  ovf,
`endif
    output AluOP, data1, data2, rt, rd, RegDst, in_valid, stall, flush,
    input  busy, out_valid, alu_result, zero, dest_reg
  );

  modport slave (
`ifdef EX_OVF_TRAP_EN
    output ovf,
`endif
    input  AluOP, data1, data2, rt, rd, RegDst, in_valid, stall, flush,
    output busy, out_valid, alu_result, zero, dest_reg
  );
endinterface

// File: rtl/ex_stage_reg.sv
// rtl/ex_stage_reg.sv - MIPS execute stage: single-cycle ALU, iterative shift-add MUL, EX/MEM register
// Optional signed-overflow trap on ADD/SUB enabled by EX_OVF_TRAP_EN.
module ex_stage_reg #(
  parameter int MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           rst,
  ex_stage_reg_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   acc, mcand, mplier, acc_step, alu_val;
  logic [CW-1:0] count;
  logic [4:0]    mul_dest, dest_sel;
  logic          busy, accept, mul_last;
  logic          out_valid_q, zero_q;
  logic [31:0]   res_q;
  logic [4:0]    dest_q;
`ifdef EX_OVF_TRAP_EN
  logic          ovf_val, ovf_q;
  assign bus.ovf = ovf_q;
`endif

  assign busy           = (state != IDLE);
  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = res_q;
  assign bus.zero       = zero_q;
  assign bus.dest_reg   = dest_q;
  assign accept   = bus.in_valid && !busy && !bus.stall && !bus.flush;
  assign dest_sel = bus.RegDst ? bus.rd : bus.rt;
  assign mul_last = (count == CW'(MUL_CYCLES - 1));
  assign acc_step = acc + (mplier[0] ? mcand : 32'd0);

  always_comb begin
    alu_val = '0;
`ifdef EX_OVF_TRAP_EN
    ovf_val = 1'b0;
`endif
    case (bus.AluOP)
      OP_AND: alu_val = bus.data1 & bus.data2;
      OP_OR:  alu_val = bus.data1 | bus.data2;
      OP_ADD: alu_val = bus.data1 + bus.data2;
      OP_NOR: alu_val = ~(bus.data1 | bus.data2);
      OP_XOR: alu_val = bus.data1 ^ bus.data2;
      OP_SUB: alu_val = bus.data1 - bus.data2;
      OP_SLT: alu_val = {31'd0, $signed(bus.data1) < $signed(bus.data2)};
      default: alu_val = '0;
    endcase
`ifdef EX_OVF_TRAP_EN
    if (bus.AluOP == OP_ADD)
      ovf_val = (bus.data1[31] == bus.data2[31]) && (alu_val[31] != bus.data1[31]);
    else if (bus.AluOP == OP_SUB)
      ovf_val = (bus.data1[31] != bus.data2[31]) && (alu_val[31] != bus.data1[31]);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && bus.AluOP == OP_MUL) state_nxt = MUL;
      MUL:  if (mul_last) state_nxt = bus.stall ? DONE : IDLE;
      DONE: if (!bus.stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      dest_q      <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      mul_dest    <= '0;
`ifdef EX_OVF_TRAP_EN
      ovf_q       <= 1'b0;
`endif
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
`ifdef EX_OVF_TRAP_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.AluOP == OP_MUL) begin
              acc         <= '0;
              mcand       <= bus.data1;
              mplier      <= bus.data2;
              count       <= '0;
              mul_dest    <= dest_sel;
              out_valid_q <= 1'b0;
`ifdef EX_OVF_TRAP_EN
              ovf_q       <= 1'b0;
`endif
            end else begin
              res_q  <= alu_val;
              zero_q <= (alu_val == 32'd0);
              dest_q <= dest_sel;
`ifdef EX_OVF_TRAP_EN
              // an overflowing ADD/SUB is dropped so nothing is written back
              out_valid_q <= !ovf_val;
              ovf_q       <= ovf_val;
`else
              out_valid_q <= 1'b1;
`endif
            end
          end else if (!bus.stall) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (!bus.stall) begin
            if (mul_last) begin
              res_q       <= acc_step;
              zero_q      <= (acc_step == 32'd0);
              dest_q      <= mul_dest;
              out_valid_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!bus.stall) begin
            res_q       <= acc;
            zero_q      <= (acc == 32'd0);
            dest_q      <= mul_dest;
            out_valid_q <= 1'b1;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/ex_stage_reg.md
Name: ex_stage_reg

Overview:
- Execute stage of the MIPS pipeline: consumes the ID/EX register outputs (ALU op, two operands, rt/rd fields, RegDst) and produces the registered EX/MEM bundle (result, zero flag, destination register, valid).
- Single-cycle ALU ops complete in one clock.
- MUL runs as an iterative 32-cycle shift-add FSM and raises busy to hold upstream.
- Supports downstream stall and pipeline flush.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL. Fixed at 32 for 32-bit operands; present for the bench only.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- AluOP  input  3  ALU operation code
- data1  input  32  operand A (rs value)
- data2  input  32  operand B (rt value or immediate)
- rt  input  5  instruction bits [20:16]
- rd  input  5  instruction bits [15:11]
- RegDst  input  1  1 selects rd as destination, 0 selects rt
- in_valid  input  1  ID/EX bundle holds a real instruction
- stall  input  1  MEM stage cannot accept; hold outputs
- flush  input  1  squash the output and any in-flight MUL
- busy  output  1  block cannot accept this cycle (combinational)
- out_valid  output  1  EX/MEM bundle valid
- alu_result  output  32  registered result
- zero  output  1  registered (alu_result == 0)
- dest_reg  output  5  registered destination register number

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_result=0, zero=0, dest_reg=0, FSM=IDLE, busy=0. Effective immediately, including mid-MUL.
- Accept condition: in_valid && !busy && !stall && !flush. dest = RegDst ? rd : rt.
- Opcodes (all results mod 2^32):
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 NOR
  - 101 XOR
  - 110 SUB (data1 - data2)
  - 111 SLT (signed; result 1 or 0)
  - 100 MUL (low 32 bits of the product)
- Single-cycle ops: on the accepting edge, load alu_result, zero and dest_reg, and set out_valid=1. Latency is 1 edge.
- FSM states: IDLE, MUL, DONE. busy = (state != IDLE).
  - IDLE: an accepted MUL latches the operands and dest, sets count=0, goes to MUL, and sets out_valid=0 on that edge.
  - MUL: each edge, if multiplier bit0 then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++.
  - MUL exit, after the 32nd iteration edge:
    - If stall=0: the same edge loads the outputs, sets out_valid=1 and returns to IDLE. Accept-to-out_valid latency is 32 edges.
    - If stall=1: go to DONE, holding the result internally.
  - DONE: wait for stall=0, then load the outputs, set out_valid=1 and go to IDLE.
- stall=1 (no flush): output registers hold their value, including out_valid. No new acceptance. A MUL in the MUL state keeps iterating.
- No accept, no stall, no flush, and no MUL completion: out_valid<=0 (bubble). Data outputs hold.
- Flush has priority over stall, completion and acceptance. On that edge: out_valid<=0, FSM->IDLE, iteration state discarded.
- busy and stall together: the input is not consumed. Upstream must hold the ID/EX bundle (busy is fed into the hazard unit).
- AluOP is don't-care when in_valid=0.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ADD/SUB with signed overflow set ovf=1 and force out_valid=0 for that instruction, so no write-back.
  - ovf is cleared on the next accepted instruction or on flush.
- When undefined: no ovf port; ADD/SUB wrap silently with normal out_valid.

Test Plan:
- Reset: assert rst mid-MUL (count=10) -> all outputs 0 and busy=0 immediately; a following ADD 5+7 gives alu_result=12 one edge later.
- ALU ops:
  - AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000.
  - SUB 3-3 -> 0, zero=1.
  - SLT -1,1 -> 1.
  - RegDst=1, rt=8, rd=9 -> dest_reg=9.
- MUL 1234*5678:
  - busy=1 for 32 edges.
  - out_valid=1 with alu_result=7006652 exactly 32 edges after accept.
  - 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Stall: hold stall=1 across MUL completion -> FSM in DONE, outputs unchanged; release stall -> result 7006652 with out_valid=1 on the next edge. Stall during an ADD -> prior outputs held.
- Flush: flush=1 at MUL iteration 20 -> out_valid=0, busy=0 next cycle, no result appears. Flush together with an accepted ADD -> out_valid=0.
- EX_OVF_TRAP_EN: ADD 0x7FFFFFFF+1 -> ovf=1, out_valid=0. Without the macro -> alu_result=0x80000000, out_valid=1.
